// File: rtl/mem_instr_loader_pkg.sv
// Shared constants and state encoding for the instruction loader.
// Loader state machine, header length and checksum width.
package mem_instr_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_ADR = 3'd1,
        HDR_LEN = 3'd2,
        DATA    = 3'd3,
        CSUM    = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Header is a 4-byte base address followed by a 4-byte word count.
    localparam logic [31:0] HDR_BYTES = 32'd8;

    // Checksum is a modulo-256 sum of payload bytes.
    localparam int CSUM_W = 8;

endpackage

// File: rtl/mem_instr_byte_packer.sv
// Little-endian byte-to-word assembler used for header and payload.
// Lane 3 completes a word; the 4th byte is passed straight through.
module mem_instr_byte_packer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_word,
    output logic        o_complete
);

    logic [23:0] r_lo;

    // Capture the lower three bytes of the word in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lo <= '0;
        end else if (i_en) begin
            unique case (i_lane)
                2'd0:    r_lo[7:0]   <= i_byte;
                2'd1:    r_lo[15:8]  <= i_byte;
                2'd2:    r_lo[23:16] <= i_byte;
                default: r_lo        <= r_lo;
            endcase
        end
    end

    assign o_word     = {i_byte, r_lo};
    assign o_complete = i_en & (i_lane == 2'd3);

endmodule

// File: rtl/mem_instr_loader.sv
// Streams a header + payload into instruction memory word writes.
// Optional checksum byte after payload: define CHECKSUM_EN.
module mem_instr_loader
    import mem_instr_loader_pkg::*;
#(
    parameter int ADR_W = 20
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [7:0]       i_byte,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_wr_en,
    output logic [ADR_W-1:0] o_wr_adr,
    output logic [31:0]      o_wr_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    state_t           r_state;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_wr_en;
    logic [ADR_W-1:0] r_wr_adr;
    logic [31:0]      r_wr_data;
    logic [31:0]      r_bcnt;
    logic [31:0]      r_wcnt;
    logic [31:0]      r_len;
    logic [ADR_W-1:0] r_base;
`ifdef CHECKSUM_EN
    logic [CSUM_W-1:0] r_sum;
    logic              r_err;
`endif

    logic        w_acc;
    logic [31:0] w_word;
    logic        w_cplt;
    logic [31:0] w_off32;
    logic        w_unused;

    assign w_acc    = i_valid & r_ready;
    assign w_off32  = r_wcnt << 2;
    assign w_unused = ^{w_off32[31:ADR_W], w_word[31:ADR_W]};

    mem_instr_byte_packer u_pack (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (w_acc),
        .i_byte     (i_byte),
        .i_lane     (r_bcnt[1:0]),
        .o_word     (w_word),
        .o_complete (w_cplt)
    );

    // Loader FSM with registered handshake, write and status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_adr  <= '0;
            r_wr_data <= '0;
            r_bcnt    <= '0;
            r_wcnt    <= '0;
            r_len     <= '0;
            r_base    <= '0;
`ifdef CHECKSUM_EN
            r_sum     <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= HDR_ADR;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                        r_bcnt  <= '0;
                        r_wcnt  <= '0;
`ifdef CHECKSUM_EN
                        r_sum   <= '0;
                        r_err   <= 1'b0;
`endif
                    end
                end
                HDR_ADR: begin
                    if (w_acc) begin
                        r_bcnt <= r_bcnt + 32'd1;
                        if (w_cplt) begin
                            r_base  <= {w_word[ADR_W-1:2], 2'b00};
                            r_state <= HDR_LEN;
                        end
                    end
                end
                HDR_LEN: begin
                    if (w_acc) begin
                        r_bcnt <= r_bcnt + 32'd1;
                        if (r_bcnt == HDR_BYTES - 32'd1) begin
                            r_len  <= w_word;
                            r_bcnt <= '0;
                            if (w_word == 32'd0) begin
`ifdef CHECKSUM_EN
                                r_state <= CSUM;
`else
                                r_state <= DONE;
                                r_ready <= 1'b0;
                                r_done  <= 1'b1;
`endif
                            end else begin
                                r_state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (w_acc) begin
                        r_bcnt <= r_bcnt + 32'd1;
`ifdef CHECKSUM_EN
                        r_sum  <= r_sum + i_byte;
`endif
                        if (w_cplt) begin
                            r_wr_en   <= 1'b1;
                            r_wr_adr  <= r_base + w_off32[ADR_W-1:0];
                            r_wr_data <= w_word;
                            r_wcnt    <= r_wcnt + 32'd1;
                            if (r_wcnt == r_len - 32'd1) begin
`ifdef CHECKSUM_EN
                                r_state <= CSUM;
`else
                                r_state <= DONE;
                                r_ready <= 1'b0;
                                r_done  <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef CHECKSUM_EN
                CSUM: begin
                    if (w_acc) begin
                        r_err   <= (i_byte != r_sum);
                        r_state <= DONE;
                        r_ready <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready   = r_ready;
    assign o_wr_en   = r_wr_en;
    assign o_wr_adr  = r_wr_adr;
    assign o_wr_data = r_wr_data;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
`ifdef CHECKSUM_EN
    assign o_err     = r_err;
`else
    assign o_err     = 1'b0;
`endif

endmodule
